// File: rtl/lsu_align_if.sv
// Request/response handshake between the core address path and lsu_align.
// master: the core side issuing requests; slave: the alignment unit.
interface lsu_align_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 17
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            address_mode;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [WIDTH-1:0]      req_wdata;
    logic                  rsp_valid;
    logic [WIDTH-1:0]      rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, address_mode, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, address_mode, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: RV32 load/store alignment unit.
// Splits a byte/halfword/word request into one or two word-aligned memory
// accesses with byte strobes and returns an extended load value or a store
// completion. Build option LSU_MISALIGNED_EN: when defined, word-crossing
// accesses are split into LO/HI accesses; when undefined, misaligned
// requests are rejected with rsp_err and no memory access.
module lsu_align #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    lsu_align_if.slave            req_if,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-3:0] mem_addr_o,
    output logic [3:0]            mem_wstrb_o,
    output logic [WIDTH-1:0]      mem_wdata_o,
    input  logic [WIDTH-1:0]      mem_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    // Byte-lane mask of an access starting at lane 0; mode 11 is a word.
    function automatic logic [3:0] size_mask(input logic [1:0] mode);
        logic [3:0] m;
        case (mode)
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Strobes for the LO word (hi=0) or the spill into the HI word (hi=1).
    function automatic logic [3:0] lane_strb(input logic [1:0] mode, input logic [1:0] off,
                                             input logic hi);
        logic [7:0] wide;
        wide = {4'b0000, size_mask(mode)} << off;
        return hi ? wide[7:4] : wide[3:0];
    endfunction

    // Store data shifted into lanes: LO gets data << 8*o, HI gets data >> 8*(4-o).
    function automatic logic [WIDTH-1:0] lane_data(input logic [WIDTH-1:0] data,
                                                   input logic [1:0] off, input logic hi);
        logic [2*WIDTH-1:0] wide;
        wide = {{WIDTH{1'b0}}, data} << {off, 3'b000};
        return hi ? wide[2*WIDTH-1:WIDTH] : wide[WIDTH-1:0];
    endfunction

    // o + s > 4: only a halfword at offset 3 or a word at a nonzero offset.
    function automatic logic crosses(input logic [1:0] mode, input logic [1:0] off);
        logic c;
        case (mode)
            2'b00:   c = 1'b0;
            2'b01:   c = (off == 2'b11);
            default: c = (off != 2'b00);
        endcase
        return c;
    endfunction

    // o % s != 0.
    function automatic logic misaligned(input logic [1:0] mode, input logic [1:0] off);
        logic m;
        case (mode)
            2'b00:   m = 1'b0;
            2'b01:   m = off[0];
            default: m = (off != 2'b00);
        endcase
        return m;
    endfunction

    state_e                state_q;
    logic                  we_q;
    logic                  unsigned_q;
    logic [1:0]            mode_q;
    logic [1:0]            off_q;
    logic [ADDR_WIDTH-3:0] word_q;
    logic [WIDTH-1:0]      wdata_q;
    logic                  cross_q;
    logic                  err_q;
    logic [WIDTH-1:0]      lo_q;
    logic                  rsp_valid_q;
    logic [WIDTH-1:0]      rsp_rdata_q;
    logic                  rsp_err_q;
    logic                  mem_en_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-3:0] mem_addr_q;
    logic [3:0]            mem_wstrb_q;
    logic [WIDTH-1:0]      mem_wdata_q;

    logic [1:0]         req_off_s;
    logic               req_cross_s;
    logic               req_reject_s;
    logic [2*WIDTH-1:0] load_cat_s;
    logic [WIDTH-1:0]   load_word_s;
    logic [WIDTH-1:0]   load_data_d;

    assign req_off_s = req_if.req_addr[1:0];

`ifdef LSU_MISALIGNED_EN
    assign req_cross_s  = crosses(req_if.address_mode, req_off_s);
    assign req_reject_s = 1'b0;
`else
    assign req_cross_s  = 1'b0;
    assign req_reject_s = misaligned(req_if.address_mode, req_off_s);
`endif

    // In FIN the last word read sits on mem_rdata_i; a crossing load pairs it with the LO buffer.
    assign load_cat_s  = cross_q ? {mem_rdata_i, lo_q} : {{WIDTH{1'b0}}, mem_rdata_i};
    assign load_word_s = WIDTH'(load_cat_s >> {off_q, 3'b000});

    // Truncate the shifted load to the access size and sign/zero-extend it.
    always_comb begin
        load_data_d = load_word_s;
        case (mode_q)
            2'b00:   load_data_d = {{(WIDTH-8){~unsigned_q & load_word_s[7]}}, load_word_s[7:0]};
            2'b01:   load_data_d = {{(WIDTH-16){~unsigned_q & load_word_s[15]}}, load_word_s[15:0]};
            default: load_data_d = load_word_s;
        endcase
    end

    // Transaction FSM: latches the request, drives registered memory strobes, builds the response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            unsigned_q  <= 1'b0;
            mode_q      <= 2'b00;
            off_q       <= 2'b00;
            word_q      <= {(ADDR_WIDTH-2){1'b0}};
            wdata_q     <= {WIDTH{1'b0}};
            cross_q     <= 1'b0;
            err_q       <= 1'b0;
            lo_q        <= {WIDTH{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {WIDTH{1'b0}};
            rsp_err_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {(ADDR_WIDTH-2){1'b0}};
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= {WIDTH{1'b0}};
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_if.req_valid) begin
                        we_q       <= req_if.req_we;
                        unsigned_q <= req_if.req_unsigned;
                        mode_q     <= req_if.address_mode;
                        off_q      <= req_off_s;
                        word_q     <= req_if.req_addr[ADDR_WIDTH-1:2];
                        wdata_q    <= req_if.req_wdata;
                        cross_q    <= req_cross_s;
                        err_q      <= req_reject_s;
                        if (req_reject_s) begin
                            state_q <= ST_FIN;
                        end else begin
                            state_q     <= ST_LO;
                            mem_en_q    <= 1'b1;
                            mem_we_q    <= req_if.req_we;
                            mem_addr_q  <= req_if.req_addr[ADDR_WIDTH-1:2];
                            mem_wstrb_q <= req_if.req_we ?
                                           lane_strb(req_if.address_mode, req_off_s, 1'b0) : 4'b0000;
                            mem_wdata_q <= lane_data(req_if.req_wdata, req_off_s, 1'b0);
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_LO: begin
                    if (cross_q) begin
                        state_q     <= ST_HI;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= we_q;
                        mem_addr_q  <= word_q + {{(ADDR_WIDTH-3){1'b0}}, 1'b1};
                        mem_wstrb_q <= we_q ? lane_strb(mode_q, off_q, 1'b1) : 4'b0000;
                        mem_wdata_q <= lane_data(wdata_q, off_q, 1'b1);
                    end else begin
                        state_q     <= ST_FIN;
                        mem_en_q    <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_wstrb_q <= 4'b0000;
                    end
                end
                ST_HI: begin
                    // LO read data arrives during HI; keep it for assembly in FIN.
                    lo_q        <= mem_rdata_i;
                    state_q     <= ST_FIN;
                    mem_en_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_wstrb_q <= 4'b0000;
                end
                ST_FIN: begin
                    if (!cross_q && !err_q) begin
                        lo_q <= mem_rdata_i;
                    end else begin
                        lo_q <= lo_q;
                    end
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= err_q;
                    rsp_rdata_q <= (err_q || we_q) ? {WIDTH{1'b0}} : load_data_d;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_if.req_ready = (state_q == ST_IDLE);
    assign req_if.rsp_valid = rsp_valid_q;
    assign req_if.rsp_rdata = rsp_rdata_q;
    assign req_if.rsp_err   = rsp_err_q;
    assign mem_en_o         = mem_en_q;
    assign mem_we_o         = mem_we_q;
    assign mem_addr_o       = mem_addr_q;
    assign mem_wstrb_o      = mem_wstrb_q;
    assign mem_wdata_o      = mem_wdata_q;

endmodule

// File: tb/tb_lsu_align.sv
// Directed testbench for lsu_align with a 16-word synchronous-read memory
// model and an access log. Expectations follow LSU_MISALIGNED_EN when defined.
module tb_lsu_align;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_align_if bus ();

    logic        mem_en;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    lsu_align dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_if      (bus),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wstrb_o (mem_wstrb),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    logic [31:0] mem [0:15];
    logic        bd_we = 1'b0;
    logic [3:0]  bd_idx = 4'd0;
    logic [31:0] bd_data = 32'd0;

    int          log_n = 0;
    logic [14:0] log_addr  [0:63];
    logic [3:0]  log_strb  [0:63];
    logic [31:0] log_wdata [0:63];
    logic        log_we    [0:63];

    // Memory model (1-cycle read latency, byte-strobed writes), backdoor preload and access log.
    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_data;
        if (mem_en) begin
            if (log_n < 64) begin
                log_addr[log_n]  <= mem_addr;
                log_strb[log_n]  <= mem_wstrb;
                log_wdata[log_n] <= mem_wdata;
                log_we[log_n]    <= mem_we;
            end
            log_n <= log_n + 1;
            if (mem_we) begin
                for (int i = 0; i < 4; i++)
                    if (mem_wstrb[i]) mem[mem_addr[3:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
            end else begin
                mem_rdata <= mem[mem_addr[3:0]];
            end
        end
    end

    int checks = 0;
    int failures = 0;
    int base;
    int nacc;
    int lat;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_ready;

    task automatic poke(input logic [3:0] idx, input logic [31:0] data);
        bd_idx = idx; bd_data = data; bd_we = 1'b1;
        @(posedge clk); #1 bd_we = 1'b0;
        @(negedge clk);
    endtask

    // Issue one request (DUT idle) and wait up to 8 cycles for the response.
    task automatic do_req(input logic we, input logic [1:0] mode, input logic uns,
                          input logic [16:0] addr, input logic [31:0] wdata);
        base = log_n;
        bus.req_valid = 1'b1; bus.req_we = we; bus.address_mode = mode;
        bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
        @(posedge clk); #1 bus.req_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                lat = i; r_rdata = bus.rsp_rdata; r_err = bus.rsp_err; r_ready = bus.req_ready;
                break;
            end
        end
        nacc = log_n - base;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0) begin failures++; $display("FAIL rst_rsp got=%b/%b exp=0/0", bus.rsp_valid, bus.rsp_err); end
        checks++; if (bus.rsp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", bus.rsp_rdata); end
        checks++; if ({mem_en, mem_we, mem_wstrb} !== 6'b0) begin failures++; $display("FAIL rst_mem_ctl got=%b exp=0", {mem_en, mem_we, mem_wstrb}); end
        checks++; if (mem_addr !== 15'h0 || mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_mem_bus got=%h/%h exp=0/0", mem_addr, mem_wdata); end
    endtask

    task automatic test_byte_store;
        do_req(1'b1, 2'b00, 1'b0, 17'h00006, 32'h000000A5);
        checks++; if (lat !== 3) begin failures++; $display("FAIL bst_lat got=%0d exp=3", lat); end
        checks++; if (nacc !== 1) begin failures++; $display("FAIL bst_nacc got=%0d exp=1", nacc); end
        checks++; if (log_addr[base] !== 15'd1 || log_strb[base] !== 4'b0100 || log_we[base] !== 1'b1)
            begin failures++; $display("FAIL bst_access got=%h/%b/%b exp=1/0100/1", log_addr[base], log_strb[base], log_we[base]); end
        checks++; if (log_wdata[base][23:16] !== 8'hA5) begin failures++; $display("FAIL bst_lane got=%h exp=a5", log_wdata[base][23:16]); end
        checks++; if (r_rdata !== 32'h0 || r_err !== 1'b0) begin failures++; $display("FAIL bst_rsp got=%h/%b exp=0/0", r_rdata, r_err); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL bst_pulse got=%b exp=0", bus.rsp_valid); end
    endtask

    task automatic test_loads;
        do_req(1'b0, 2'b00, 1'b0, 17'h00006, 32'h0);
        checks++; if (lat !== 3 || r_rdata !== 32'hFFFFFFA5) begin failures++; $display("FAIL lb_signed got=%h lat=%0d exp=ffffffa5 lat=3", r_rdata, lat); end
        checks++; if (nacc !== 1 || log_we[base] !== 1'b0 || log_strb[base] !== 4'b0000) begin failures++; $display("FAIL lb_access got=%0d/%b/%b exp=1/0/0000", nacc, log_we[base], log_strb[base]); end
        do_req(1'b0, 2'b00, 1'b1, 17'h00006, 32'h0);
        checks++; if (r_rdata !== 32'h000000A5) begin failures++; $display("FAIL lbu got=%h exp=000000a5", r_rdata); end
        do_req(1'b0, 2'b01, 1'b0, 17'h00002, 32'h0);
        checks++; if (r_rdata !== 32'hFFFF8001) begin failures++; $display("FAIL lh_signed got=%h exp=ffff8001", r_rdata); end
        do_req(1'b0, 2'b01, 1'b1, 17'h00002, 32'h0);
        checks++; if (r_rdata !== 32'h00008001) begin failures++; $display("FAIL lhu got=%h exp=00008001", r_rdata); end
        do_req(1'b0, 2'b00, 1'b0, 17'h00001, 32'h0);
        checks++; if (r_rdata !== 32'h0000007F) begin failures++; $display("FAIL lb_pos got=%h exp=0000007f", r_rdata); end
    endtask

    task automatic test_word_cross;
        poke(4'd1, 32'h44332211);
        do_req(1'b0, 2'b10, 1'b0, 17'h00005, 32'h0);
`ifdef LSU_MISALIGNED_EN
        checks++; if (lat !== 4) begin failures++; $display("FAIL lwx_lat got=%0d exp=4", lat); end
        checks++; if (nacc !== 2 || log_addr[base] !== 15'd1 || log_addr[base+1] !== 15'd2)
            begin failures++; $display("FAIL lwx_addr got=%0d %h %h exp=2 1 2", nacc, log_addr[base], log_addr[base+1]); end
        checks++; if (r_rdata !== 32'h55443322 || r_err !== 1'b0) begin failures++; $display("FAIL lwx_data got=%h/%b exp=55443322/0", r_rdata, r_err); end
`else
        checks++; if (lat !== 2) begin failures++; $display("FAIL lwx_lat got=%0d exp=2", lat); end
        checks++; if (nacc !== 0) begin failures++; $display("FAIL lwx_noacc got=%0d exp=0", nacc); end
        checks++; if (r_rdata !== 32'h0 || r_err !== 1'b1) begin failures++; $display("FAIL lwx_err got=%h/%b exp=0/1", r_rdata, r_err); end
`endif
    endtask

    task automatic test_half_store_cross;
        do_req(1'b1, 2'b01, 1'b0, 17'h00003, 32'h0000BEEF);
`ifdef LSU_MISALIGNED_EN
        checks++; if (lat !== 4 || nacc !== 2) begin failures++; $display("FAIL shx_lat got=%0d/%0d exp=4/2", lat, nacc); end
        checks++; if (log_addr[base] !== 15'd0 || log_strb[base] !== 4'b1000 || log_wdata[base][31:24] !== 8'hEF)
            begin failures++; $display("FAIL shx_lo got=%h/%b/%h exp=0/1000/ef", log_addr[base], log_strb[base], log_wdata[base][31:24]); end
        checks++; if (log_addr[base+1] !== 15'd1 || log_strb[base+1] !== 4'b0001 || log_wdata[base+1][7:0] !== 8'hBE)
            begin failures++; $display("FAIL shx_hi got=%h/%b/%h exp=1/0001/be", log_addr[base+1], log_strb[base+1], log_wdata[base+1][7:0]); end
        do_req(1'b0, 2'b10, 1'b0, 17'h00004, 32'h0);
        checks++; if (r_rdata !== 32'h443322BE) begin failures++; $display("FAIL shx_rd1 got=%h exp=443322be", r_rdata); end
`else
        checks++; if (lat !== 2 || nacc !== 0 || r_err !== 1'b1) begin failures++; $display("FAIL shx_err got=%0d/%0d/%b exp=2/0/1", lat, nacc, r_err); end
        do_req(1'b1, 2'b01, 1'b0, 17'h00002, 32'h00001234);
        checks++; if (lat !== 3 || r_err !== 1'b0 || log_strb[base] !== 4'b1100) begin failures++; $display("FAIL sh_aligned got=%0d/%b/%b exp=3/0/1100", lat, r_err, log_strb[base]); end
`endif
    endtask

    task automatic test_back_to_back;
        do_req(1'b1, 2'b10, 1'b0, 17'h0000C, 32'hCAFEF00D);
        checks++; if (r_ready !== 1'b1 || log_strb[base] !== 4'b1111 || log_addr[base] !== 15'd3)
            begin failures++; $display("FAIL b2b_store got=%b/%b/%h exp=1/1111/3", r_ready, log_strb[base], log_addr[base]); end
        do_req(1'b0, 2'b10, 1'b0, 17'h0000C, 32'h0);
        checks++; if (lat !== 3 || r_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL b2b_load got=%h lat=%0d exp=cafef00d lat=3", r_rdata, lat); end
        do_req(1'b0, 2'b11, 1'b0, 17'h00008, 32'h0);
        checks++; if (lat !== 3 || r_rdata !== 32'h88776655) begin failures++; $display("FAIL mode11 got=%h lat=%0d exp=88776655 lat=3", r_rdata, lat); end
    endtask

    task automatic test_reset_mid;
        int seen;
        poke(4'd0, 32'h80017F02);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.address_mode = 2'b01; bus.req_unsigned = 1'b0;
`ifdef LSU_MISALIGNED_EN
        bus.req_addr = 17'h00003;
`else
        bus.req_addr = 17'h00002;
`endif
        bus.req_wdata = 32'h0000BEEF;
        @(posedge clk); #1 bus.req_valid = 1'b0;
        @(negedge clk);
`ifdef LSU_MISALIGNED_EN
        @(negedge clk);
`endif
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1 || mem_en !== 1'b0 || bus.rsp_valid !== 1'b0)
            begin failures++; $display("FAIL rmid_state got=%b/%b/%b exp=1/0/0", bus.req_ready, mem_en, bus.rsp_valid); end
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL rmid_norsp got=%0d exp=0", seen); end
        do_req(1'b0, 2'b10, 1'b0, 17'h00000, 32'h0);
`ifdef LSU_MISALIGNED_EN
        checks++; if (lat !== 3 || r_rdata !== 32'hEF017F02) begin failures++; $display("FAIL rmid_load got=%h lat=%0d exp=ef017f02 lat=3", r_rdata, lat); end
`else
        checks++; if (lat !== 3 || r_rdata !== 32'hBEEF7F02) begin failures++; $display("FAIL rmid_load got=%h lat=%0d exp=beef7f02 lat=3", r_rdata, lat); end
`endif
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.address_mode = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 17'h0; bus.req_wdata = 32'h0;
        poke(4'd0, 32'h80017F02);
        poke(4'd1, 32'h00A50000);
        poke(4'd2, 32'h88776655);
        poke(4'd3, 32'h00000000);
        test_reset;
        test_byte_store;
        test_loads;
        test_word_cross;
        test_half_store_cross;
        test_back_to_back;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
